mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of each requester data word and of the shared output bus.
REQ-002 Parameter BURST_MAX, default 8, maximum accepted beats per grant when MUX_ARB_BURST_LIMIT_EN is defined; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  requester N has a beat to send; doubles as beat-valid while granted.
REQ-006 last0, last1  input  1 each  current beat of requester N is the final beat of its transfer.
REQ-007 data0, data1  input  DATA_W each  requester N data.
REQ-008 gnt0, gnt1  output  1 each  registered grant; at most one is high in any cycle.
REQ-009 sel  output  1  shared-mux select: 1 while gnt1 is high, 0 otherwise.
REQ-010 out_data  output  DATA_W  sel ? data1 : data0, combinational.
REQ-011 out_valid  output  1  (gnt0 & req0) | (gnt1 & req1).
REQ-012 out_ready  input  1  consumer accepts the beat on out_bus; a beat transfers when out_valid & out_ready.

Function
REQ-013 The state machine SHALL have three states, IDLE, GRANT0 and GRANT1; gntN SHALL equal (state == GRANTN).
REQ-014 In IDLE with exactly one reqN high, the next state SHALL be GRANTN (one-cycle arbitration latency).
REQ-015 In IDLE with req0 and req1 both high, the next state SHALL be GRANT of the requester named by the 1-bit priority pointer `prio`.
REQ-016 In GRANTN, an accepted beat with lastN high SHALL end the grant: if the other requester's req is high, the next state is the other GRANT state with no idle bubble; otherwise it is IDLE.
REQ-017 Each grant end SHALL set prio to the other requester, giving round-robin fairness.
REQ-018 While in GRANTN with reqN low, out_valid SHALL be 0 and the grant SHALL be held; the grant SHALL NOT time out.
REQ-019 lastN SHALL be ignored unless the beat is accepted; out_ready low SHALL stall the state, counter and prio.
REQ-020 The non-granted requester's req, last and data SHALL have no effect on out_data, out_valid or the current state.
REQ-021 The beat counter SHALL be 8 bits wide, cleared on every grant entry, and incremented per accepted beat; it saturates at 255.

Reset
REQ-022 While rst is high, the next state SHALL be IDLE, prio SHALL be 0 and the beat counter SHALL be 0, whatever the current state or inputs.
REQ-023 After reset, gnt0=0, gnt1=0 and sel=0; out_valid=0; out_data shows data0.
REQ-024 Reset during a transfer SHALL abort it with no further beats; the aborted requester re-arbitrates from IDLE.

Configuration
REQ-025 With MUX_ARB_BURST_LIMIT_EN defined, an accepted beat that brings the count to BURST_MAX while the other requester's req is high SHALL end the grant as in REQ-016/017, even if lastN is low; the preempted requester SHALL re-request to send its remaining beats.
REQ-026 With MUX_ARB_BURST_LIMIT_EN defined and the other requester idle, the grant SHALL continue past BURST_MAX until last; the counter saturates.
REQ-027 Without MUX_ARB_BURST_LIMIT_EN, grants SHALL end only on an accepted last beat; BURST_MAX is unused.

Verification
REQ-028 Reset, then req0=1, last0=1 at cycle 1, out_ready=1 -> gnt0=1 at cycle 2, one beat of data0 on out_data, IDLE at cycle 3, prio=1.
REQ-029 req0 and req1 both high from reset, 3-beat transfers each, out_ready=1 -> grant order 0,1,0,1 with no idle cycle between grants; sel toggles 0->1->0.
REQ-030 GRANT1 with out_ready=0 for 4 cycles and last1=1 -> state, sel=1 and out_data=data1 held; the grant ends 1 cycle after out_ready rises.
REQ-031 rst=1 mid-transfer in GRANT1 -> gnt1=0, sel=0, prio=0 in the following cycle; no beat accepted while rst is high.
REQ-032 MUX_ARB_BURST_LIMIT_EN, BURST_MAX=8, 20-beat transfer from requester 0 with req1 high -> gnt0 drops after beat 8 and gnt1 rises the next cycle; with req1 low -> all 20 beats sent in one grant.
REQ-033 Without the macro, same 20-beat stimulus with req1 high -> all 20 beats are sent before gnt1 rises.

Source files
------------

// File: rtl/mux_arbiter_if.sv
// Bundle between two requesters, the two-way round-robin arbiter and the shared output bus.
// Handshake: a beat transfers on a rising clk edge when out_valid & out_ready are both high;
// reqN is the requester's valid while gntN is high, and lastN only counts on a transferring beat.
interface mux_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              last0;
    logic              last1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              gnt0;
    logic              gnt1;
    logic              sel;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output req0, req1, last0, last1, data0, data1, out_ready,
        input  gnt0, gnt1, sel, out_data, out_valid
    );

    modport slave (
        input  req0, req1, last0, last1, data0, data1, out_ready,
        output gnt0, gnt1, sel, out_data, out_valid
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving a shared data mux; grants end on an accepted last beat.
// Optional macro MUX_ARB_BURST_LIMIT_EN: preempt a grant after BURST_MAX beats when the other side waits.
module mux_arbiter #(
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux_arbiter_if.slave        bus,
    output logic [1:0]          dbg_state,
    output logic                dbg_prio,
    output logic [7:0]          dbg_cnt
);
    if (BURST_MAX < 2 || BURST_MAX > 255) begin : g_bad_burst_max
        $error("mux_arbiter: BURST_MAX must be in 2..255");
    end

    // Debug encoding: IDLE=0, GRANT0=1, GRANT1=2.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t            state;
    logic              prio;
    logic [7:0]        cnt;

    logic              granted;
    logic              own_req;
    logic              own_last;
    logic              other_req;
    logic              beat;
    logic              limit_hit;
    logic              grant_end;
    logic [8:0]        cnt_inc;
    logic [7:0]        cnt_sat;
    logic [DATA_W-1:0] mux_data;

    assign granted   = (state == GRANT0) || (state == GRANT1);
    assign own_req   = (state == GRANT1) ? bus.req1  : bus.req0;
    assign own_last  = (state == GRANT1) ? bus.last1 : bus.last0;
    assign other_req = (state == GRANT1) ? bus.req0  : bus.req1;
    assign beat      = granted & own_req & bus.out_ready;
    assign cnt_inc   = {1'b0, cnt} + 9'd1;
    assign cnt_sat   = cnt_inc[8] ? 8'hFF : cnt_inc[7:0];

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam logic [8:0] BURST_LIM = 9'(BURST_MAX);
    // Compared against the pre-saturation value so the hit fires exactly once per grant.
    assign limit_hit = (cnt_inc == BURST_LIM);
`else
    assign limit_hit = 1'b0;
`endif

    assign grant_end = beat & (own_last | (limit_hit & other_req));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (bus.req0 && bus.req1) begin
                        state <= prio ? GRANT1 : GRANT0;
                    end else if (bus.req0) begin
                        state <= GRANT0;
                    end else if (bus.req1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (grant_end) begin
                        // Hand over to the other side, directly if it is already waiting.
                        prio <= (state == GRANT0);
                        cnt  <= 8'd0;
                        if (other_req) begin
                            state <= (state == GRANT0) ? GRANT1 : GRANT0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (beat) begin
                        cnt <= cnt_sat;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign mux_data      = (state == GRANT1) ? bus.data1 : bus.data0;
    assign bus.gnt0      = (state == GRANT0);
    assign bus.gnt1      = (state == GRANT1);
    assign bus.sel       = (state == GRANT1);
    assign bus.out_data  = mux_data;
    assign bus.out_valid = ((state == GRANT0) & bus.req0) | ((state == GRANT1) & bus.req1);

    assign dbg_state = state;
    assign dbg_prio  = prio;
    assign dbg_cnt   = cnt;
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: bench-side requesters, a grant-level reference model
// checked every cycle, an expected-beat queue, and literal checks for the key scenarios.
module tb_mux_arbiter;
    localparam int DATA_W    = 16;
    localparam int BURST_MAX = 8;
`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_arbiter_if #(.DATA_W(DATA_W)) bus ();
    logic [1:0] dbg_state;
    logic       dbg_prio;
    logic [7:0] dbg_cnt;

    mux_arbiter #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_prio  (dbg_prio),
        .dbg_cnt   (dbg_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bench requesters ----------------
    int          rem[2];
    int          trans[2];
    int          reload_len[2];
    int          sent[2];
    bit          pause[2];
    logic [15:0] base[2];
    bit          ready;

    task automatic apply();
        bus.req0      = (rem[0] > 0) && !pause[0];
        bus.req1      = (rem[1] > 0) && !pause[1];
        bus.last0     = (rem[0] == 1);
        bus.last1     = (rem[1] == 1);
        bus.data0     = base[0] + 16'(sent[0]);
        bus.data1     = base[1] + 16'(sent[1]);
        bus.out_ready = ready;
    endtask

    task automatic step();
        bit a[2];
        @(negedge clk);
        a[0] = bus.gnt0 & bus.req0 & bus.out_ready & !rst;
        a[1] = bus.gnt1 & bus.req1 & bus.out_ready & !rst;
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (a[n]) begin
                rem[n]--;
                sent[n]++;
                if (rem[n] == 0 && trans[n] > 0) begin
                    trans[n]--;
                    rem[n] = reload_len[n];
                end
            end
        end
        apply();
        #1;
    endtask

    // ---------------- reference model ----------------
    int m_owner = -1;
    int m_prio  = 0;
    int m_cnt   = 0;
    int m_gbeats = 0;
    int m_nxt;
    int m_o;
    bit m_r[2];
    bit m_l[2];
    int grant_log[$];
    int beats_log[$];
    logic [DATA_W-1:0] exp_q[$];

    always @(posedge clk) begin
        m_r[0] = bus.req0;  m_r[1] = bus.req1;
        m_l[0] = bus.last0; m_l[1] = bus.last1;
        if (rst) begin
            m_owner = -1;
            m_prio  = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            if (m_r[0] && m_r[1]) m_nxt = m_prio;
            else if (m_r[0])      m_nxt = 0;
            else if (m_r[1])      m_nxt = 1;
            else                  m_nxt = -1;
            if (m_nxt >= 0) begin
                m_owner = m_nxt; m_cnt = 0; m_gbeats = 0;
                grant_log.push_back(m_nxt);
            end
        end else begin
            m_o = m_owner;
            if (m_r[m_o] && bus.out_ready) begin
                m_gbeats++;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (m_l[m_o] || (LIMIT && m_r[1-m_o] && m_gbeats == BURST_MAX)) begin
                    beats_log.push_back(m_gbeats);
                    m_prio = 1 - m_o;
                    if (m_r[1-m_o]) begin
                        m_owner = 1 - m_o; m_cnt = 0; m_gbeats = 0;
                        grant_log.push_back(1 - m_o);
                    end else begin
                        m_owner = -1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare and beat scoreboard ----------------
    always @(negedge clk) begin
        check("gnt0", bus.gnt0, m_owner == 0);
        check("gnt1", bus.gnt1, m_owner == 1);
        check("sel", bus.sel, m_owner == 1);
        check("state", dbg_state, m_owner + 1);
        check("prio", dbg_prio, m_prio);
        check("out_valid", bus.out_valid,
              (m_owner == 0 && bus.req0) || (m_owner == 1 && bus.req1));
        check("out_data", bus.out_data, (m_owner == 1) ? bus.data1 : bus.data0);
        if (m_owner >= 0) check("cnt", dbg_cnt, m_cnt);
        if (!rst && bus.out_ready && ((m_owner == 0 && bus.req0) || (m_owner == 1 && bus.req1)))
            exp_q.push_back((m_owner == 1) ? bus.data1 : bus.data0);
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
            else                   check("beat_data", bus.out_data, exp_q.pop_front());
        end
    end

    // ---------------- sequences ----------------
    task automatic do_reset();
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            rem[n] = 0; trans[n] = 0; reload_len[n] = 0; sent[n] = 0; pause[n] = 1'b0;
        end
        ready = 1'b1;
        apply();
        step();
        step();
        rst = 1'b0;
        grant_log.delete();
        beats_log.delete();
    endtask

    task automatic drain(input int max_cycles);
        int c;
        c = 0;
        while ((rem[0] > 0 || rem[1] > 0 || m_owner >= 0) && c < max_cycles) begin
            step();
            c++;
        end
        check("drain_done", (c < max_cycles), 1);
    endtask

    initial begin
        base[0] = 16'hA000;
        base[1] = 16'hB000;
        do_reset();

        // Reset state
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_gnt1", bus.gnt1, 0);
        check("rst_sel", bus.sel, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 16'hA000);
        check("rst_prio", dbg_prio, 0);

        // Single one-beat transfer from requester 0
        rem[0] = 1; apply();
        step();
        check("one_gnt0", bus.gnt0, 1);
        check("one_valid", bus.out_valid, 1);
        check("one_data", bus.out_data, 16'hA000);
        step();
        check("one_idle", {bus.gnt1, bus.gnt0}, 2'b00);
        check("one_prio", dbg_prio, 1);

        // Both requesting, two 3-beat transfers each
        do_reset();
        rem[0] = 3; rem[1] = 3; trans[0] = 1; trans[1] = 1; reload_len[0] = 3; reload_len[1] = 3;
        apply();
        for (int i = 1; i <= 12; i++) begin
            step();
            check("rr_sel", bus.sel, ((i - 1) / 3) % 2);
            check("rr_busy", bus.gnt0 | bus.gnt1, 1);
        end
        step();
        check("rr_end_idle", {bus.gnt1, bus.gnt0}, 2'b00);
        check("rr_order_len", grant_log.size(), 4);
        check("rr_order", {grant_log[0][1:0], grant_log[1][1:0], grant_log[2][1:0], grant_log[3][1:0]},
              8'b00_01_00_01);

        // Stall on out_ready with last1 high; requester 0 waits meanwhile
        do_reset();
        ready = 1'b0; rem[1] = 1; apply();
        step();
        rem[0] = 2; apply();
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_gnt1", bus.gnt1, 1);
            check("stall_sel", bus.sel, 1);
            check("stall_data", bus.out_data, 16'hB000);
        end
        ready = 1'b1; apply();
        step();
        check("stall_end_gnt1", bus.gnt1, 0);
        check("stall_next_gnt0", bus.gnt0, 1);
        drain(20);

        // Granted requester drops req: grant held, no valid
        do_reset();
        rem[0] = 3; apply();
        step();
        step();
        pause[0] = 1'b1; rem[1] = 1; apply();
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_gnt0", bus.gnt0, 1);
            check("hold_valid", bus.out_valid, 0);
        end
        pause[0] = 1'b0; apply();
        drain(20);
        check("hold_beats0", beats_log[0], 3);
        check("hold_order", {grant_log[0][1:0], grant_log[1][1:0]}, 4'b00_01);

        // Reset in the middle of a GRANT1 transfer
        do_reset();
        rem[1] = 5; apply();
        step();
        step();
        rst = 1'b1; apply();
        step();
        check("abort_gnt1", bus.gnt1, 0);
        check("abort_sel", bus.sel, 0);
        check("abort_prio", dbg_prio, 0);
        check("abort_sent", sent[1], 1);
        rst = 1'b0; apply();
        step();
        check("abort_regrant", bus.gnt1, 1);
        drain(20);

        // 20-beat burst from requester 0 with requester 1 waiting
        do_reset();
        rem[0] = 20; rem[1] = 3; apply();
        drain(60);
        check("burst_first_len", beats_log[0], LIMIT ? 8 : 20);
        check("burst_second_owner", grant_log[1], 1);
        check("burst_grants", grant_log.size(), LIMIT ? 3 : 2);

        // 20-beat burst alone: one grant
        do_reset();
        rem[0] = 20; apply();
        drain(60);
        check("solo_len", beats_log[0], 20);
        check("solo_grants", grant_log.size(), 1);

        // Beat counter saturation
        do_reset();
        rem[0] = 300; apply();
        for (int i = 0; i < 261; i++) step();
        check("sat_gnt0", bus.gnt0, 1);
        check("sat_cnt", dbg_cnt, 8'd255);
        drain(100);

        check("beat_missing", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
